// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment types and the hex glyph table (active-high, {G..A})
package seg7_pkg;
  typedef logic [6:0] seg7_t;
  localparam seg7_t SEG_OFF = 7'h7F;
  localparam seg7_t HEX7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: nibble to active-high segment pattern
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg7_t      seg
);
  assign seg = HEX7[nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode seven-segment scanner with per-digit register file
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter  int N_DIGITS  = 8,
  parameter  int DIGIT_DIV = 100000,
  parameter  int BLANK_CYC = 2,
  localparam int ADDR_W    = $clog2(N_DIGITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [3:0]          wr_data,
  input  logic                wr_dp,
  input  logic [N_DIGITS-1:0] blank_mask,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [ADDR_W-1:0]   scan_idx
);
  localparam int DIV_W = $clog2(DIGIT_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIGIT_DIV - 1);
  localparam logic [DIV_W-1:0]  BLK      = DIV_W'(BLANK_CYC);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_DIGITS - 1);
  localparam logic [ADDR_W:0]   N_CNT    = (ADDR_W + 1)'(N_DIGITS);
  logic [3:0]          digit [N_DIGITS];
  logic [N_DIGITS-1:0] dp_reg;
  logic [DIV_W-1:0]    div_cnt;
  logic                blank;
  seg7_t               glyph;
  seg7_hex_decoder u_dec (.nib(digit[scan_idx]), .seg(glyph));
  assign blank = (div_cnt < BLK) || blank_mask[scan_idx];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_DIGITS; i++) digit[i] <= '0;
      dp_reg <= '0;
    end else if (wr_en && {1'b0, wr_addr} < N_CNT) begin
      digit[wr_addr]  <= wr_data;
      dp_reg[wr_addr] <= wr_dp;
    end
  end
  // explicit wrap keeps non-power-of-2 digit counts in range
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      scan_idx <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (div_cnt == DIV_LAST) scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= blank ? '1 : ~({{(N_DIGITS - 1){1'b0}}, 1'b1} << scan_idx);
      seg <= blank ? SEG_OFF : ~glyph;
      dp  <= blank | ~dp_reg[scan_idx];
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench driving an 8-digit and a 6-digit scanner from shared random stimulus
module tb_seg7_scan_driver;
  localparam int D = 4;
  localparam int B = 1;
  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] idx;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       wr_dp = 1'b0;
  logic [7:0] mask = '0;
  logic [7:0] an8;
  logic [5:0] an6;
  logic [6:0] seg8, seg6;
  logic       dp8, dp6;
  logic [2:0] idx8, idx6;
  int checks = 0;
  int errors = 0;
  exp_t q [2][$];
  logic [6:0] hex [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int         nd [2] = '{8, 6};
  logic [3:0] md [2][8];
  logic       mdp [2][8];
  int         k [2];

  seg7_scan_driver #(.N_DIGITS(8), .DIGIT_DIV(D), .BLANK_CYC(B)) dut8 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp),
    .blank_mask(mask), .an(an8), .seg(seg8), .dp(dp8), .scan_idx(idx8));
  seg7_scan_driver #(.N_DIGITS(6), .DIGIT_DIV(D), .BLANK_CYC(B)) dut6 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp),
    .blank_mask(mask[5:0]), .an(an6), .seg(seg6), .dp(dp6), .scan_idx(idx6));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference: cycle t after reset release lies in slot t/D, digit (t/D)%N, offset t%D
  initial forever begin
    @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      exp_t e;
      int t, i;
      logic bl;
      if (rst) begin
        e = '{8'hFF, 7'h7F, 1'b1, 3'd0};
        k[j] = 0;
        for (int n = 0; n < 8; n++) begin
          md[j][n] = '0;
          mdp[j][n] = 1'b0;
        end
      end else begin
        t = k[j];
        i = (t / D) % nd[j];
        bl = (t % D) < B || mask[i];
        e.an = bl ? 8'hFF : ~(8'd1 << i);
        e.seg = bl ? 7'h7F : ~hex[md[j][i]];
        e.dp = bl | ~mdp[j][i];
        k[j] = k[j] + 1;
        e.idx = 3'(((k[j]) / D) % nd[j]);
        if (wr_en && int'(wr_addr) < nd[j]) begin
          md[j][wr_addr] = wr_data;
          mdp[j][wr_addr] = wr_dp;
        end
      end
      q[j].push_back(e);
    end
  end

  initial forever begin
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      exp_t e;
      if (q[j].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard%0d: queue empty at %0t", j, $time);
      end else begin
        e = q[j].pop_front();
        if (j == 0) begin
          chk("an8", an8, e.an);
          chk("seg8", seg8, e.seg);
          chk("dp8", dp8, e.dp);
          chk("idx8", idx8, e.idx);
        end else begin
          chk("an6", {2'b11, an6}, e.an);
          chk("seg6", seg6, e.seg);
          chk("dp6", dp6, e.dp);
          chk("idx6", idx6, e.idx);
        end
      end
    end
    checks++;
    assert ($countones(~an8) <= 1 && $countones(~an6) <= 1) else begin
      errors++;
      $display("FAIL one_hot_anode: an8=%h an6=%h", an8, an6);
    end
  end

  task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic p);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_dp = p;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idx(input logic [2:0] target, input int off);
    int n;
    n = 0;
    while (idx8 != target && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL wait_idx: scan_idx=%0d never reached %0d", idx8, target);
    end
    repeat (off) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wr(3'd0, 4'h0, 1'b1);
    wr(3'd1, 4'hA, 1'b0);
    repeat (64) @(negedge clk);
    mask = 8'h04;
    repeat (40) @(negedge clk);
    mask = 8'h00;
    wr(3'd7, 4'h5, 1'b1);
    repeat (40) @(negedge clk);
    wait_idx(3'd3, 2);
    wr(3'd3, 4'h8, 1'b0);
    repeat (6) @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 4'($urandom_range(0, 15));
      wr_dp = 1'($urandom_range(0, 1));
      mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    wr_en = 1'b0;
    mask = 8'h00;
    wr(3'd5, 4'hC, 1'b1);
    wait_idx(3'd5, 2);
    rst = 1'b1;
    wr_en = 1'b1;
    wr_addr = 3'd2;
    wr_data = 4'hF;
    wr_dp = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wr_en = 1'b0;
    repeat (40) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
